// File: rtl/axi_sram_slave_if.sv
// ---------------------------------------------------------------------------
// axi_channel: one AXI4 channel bundle (AW, W, B, AR, R).
//   master modport : drives requests (aw/w/ar, b_ready, r_ready)
//   slave  modport : drives aw/ar/w_ready and the r_* / b_* response signals
// Parameters: ID_WIDTH, ADDR_WIDTH, DATA_WIDTH (strobe width = DATA_WIDTH/8).
// ---------------------------------------------------------------------------
interface axi_channel #(
    parameter int ID_WIDTH   = 8,
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64
);
    // write address
    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_lock;
    logic [3:0]              aw_cache;
    logic [2:0]              aw_prot;
    logic                    aw_valid;
    logic                    aw_ready;
    // write data
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;
    logic                    w_valid;
    logic                    w_ready;
    // write response
    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic                    b_user;
    logic                    b_valid;
    logic                    b_ready;
    // read address
    logic [ID_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    ar_lock;
    logic [3:0]              ar_cache;
    logic [2:0]              ar_prot;
    logic                    ar_valid;
    logic                    ar_ready;
    // read data
    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic                    r_user;
    logic                    r_valid;
    logic                    r_ready;

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// ---------------------------------------------------------------------------
// axi_sram_slave: AXI4 responder in front of a single-port synchronous SRAM.
// One transaction at a time, reads and writes arbitrated round-robin.
// FIXED / INCR / WRAP bursts, narrow sizes, write strobes.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   slave      axi_channel.slave AXI port
//   mem_req    SRAM access strobe
//   mem_we     1 = write, 0 = read
//   mem_addr   SRAM word address
//   mem_wdata  SRAM write data
//   mem_wstrb  SRAM byte write enables
//   mem_rdata  SRAM read data, valid one cycle after a read request
// ---------------------------------------------------------------------------
module axi_sram_slave #(
    parameter int ID_WIDTH       = 8,
    parameter int ADDR_WIDTH     = 48,
    parameter int DATA_WIDTH     = 64,
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    axi_channel.slave                 slave,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   mem_wstrb,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int OFF        = $clog2(STRB_WIDTH);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP} state_e;

    state_e                  state_q, state_d;
    logic                    prio_wr_q, prio_wr_d;   // 0: read wins a tie, 1: write wins
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [2:0]              size_q, size_d;
    logic [1:0]              burst_q, burst_d;
    logic                    err_q, err_d;
    logic                    rd_first_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic                    grant_rd, grant_wr;
    logic                    last_beat;
    logic [ADDR_WIDTH-1:0]   addr_nxt;

    // Burst legality, evaluated once when the address is accepted.
    function automatic logic accept_err(input logic [ADDR_WIDTH-1:0] a,
                                        input logic [7:0]            len,
                                        input logic [2:0]            size,
                                        input logic [1:0]            burst);
        logic [ADDR_WIDTH-1:0] step_mask;
        step_mask  = (ADDR_WIDTH'(1) << size) - ADDR_WIDTH'(1);
        accept_err = 1'b0;
        if (int'(size) > OFF) accept_err = 1'b1;
        if (burst == 2'b11)   accept_err = 1'b1;
        if (burst == BURST_WRAP) begin
            if (!(len inside {8'd1, 8'd3, 8'd7, 8'd15})) accept_err = 1'b1;
            if ((a & step_mask) != '0)                   accept_err = 1'b1;
        end
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] advance(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [7:0]            len,
                                                      input logic [2:0]            size,
                                                      input logic [1:0]            burst);
        logic [ADDR_WIDTH-1:0] step, bound;
        step  = ADDR_WIDTH'(1) << size;
        bound = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
        case (burst)
            BURST_INCR: advance = (a & ~(step - ADDR_WIDTH'(1))) + step;
            // Keep the bits above the wrap boundary, wrap the ones below it.
            BURST_WRAP: advance = (a & ~(bound - ADDR_WIDTH'(1))) |
                                  ((a + step) & (bound - ADDR_WIDTH'(1)));
            default:    advance = a;
        endcase
    endfunction

    // On a tie the side not served last wins.
    assign grant_rd  = slave.ar_valid && !(slave.aw_valid && prio_wr_q);
    assign grant_wr  = slave.aw_valid && !(slave.ar_valid && !prio_wr_q);
    assign last_beat = (cnt_q == len_q);
    assign addr_nxt  = advance(addr_q, len_q, size_q, burst_q);

    assign slave.r_user = 1'b0;
    assign slave.b_user = 1'b0;

    logic unused_sideband;
    assign unused_sideband = ^{slave.aw_lock, slave.aw_cache, slave.aw_prot,
                               slave.ar_lock, slave.ar_cache, slave.ar_prot};

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        prio_wr_d = prio_wr_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        size_d    = size_q;
        burst_d   = burst_q;
        err_d     = err_q;

        slave.aw_ready = 1'b0;
        slave.ar_ready = 1'b0;
        slave.w_ready  = 1'b0;
        slave.r_valid  = 1'b0;
        slave.r_data   = '0;
        slave.r_resp   = RESP_OKAY;
        slave.r_last   = 1'b0;
        slave.r_id     = '0;
        slave.b_valid  = 1'b0;
        slave.b_resp   = RESP_OKAY;
        slave.b_id     = '0;

        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;

        case (state_q)
            IDLE: begin
                // Ready is held low while reset is asserted even if a master
                // already raises valid.
                if (grant_rd && !rst) begin
                    slave.ar_ready = 1'b1;
                    id_d      = slave.ar_id;
                    addr_d    = slave.ar_addr;
                    len_d     = slave.ar_len;
                    size_d    = slave.ar_size;
                    burst_d   = slave.ar_burst;
                    cnt_d     = '0;
                    err_d     = accept_err(slave.ar_addr, slave.ar_len, slave.ar_size, slave.ar_burst);
                    prio_wr_d = 1'b1;
                    state_d   = RD_REQ;
                end else if (grant_wr && !rst) begin
                    slave.aw_ready = 1'b1;
                    id_d      = slave.aw_id;
                    addr_d    = slave.aw_addr;
                    len_d     = slave.aw_len;
                    size_d    = slave.aw_size;
                    burst_d   = slave.aw_burst;
                    cnt_d     = '0;
                    err_d     = accept_err(slave.aw_addr, slave.aw_len, slave.aw_size, slave.aw_burst);
                    prio_wr_d = 1'b0;
                    state_d   = WR_DATA;
                end
            end

            RD_REQ: begin
                if (!err_q) begin
                    mem_req  = 1'b1;
                    mem_addr = addr_q[MEM_ADDR_WIDTH+OFF-1:OFF];
                end
                state_d = RD_DATA;
            end

            RD_DATA: begin
                slave.r_valid = 1'b1;
                slave.r_id    = id_q;
                slave.r_last  = last_beat;
                slave.r_resp  = err_q ? RESP_SLVERR : RESP_OKAY;
                // SRAM data is live only in the first cycle; afterwards the
                // captured copy keeps r_data stable under back-pressure.
                if (!err_q) slave.r_data = rd_first_q ? mem_rdata : rdata_q;
                if (slave.r_ready) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_nxt;
                        cnt_d   = cnt_q + 8'd1;
                        state_d = RD_REQ;
                    end
                end
            end

            WR_DATA: begin
                slave.w_ready = 1'b1;
                if (slave.w_valid) begin
                    if (!err_q) begin
                        mem_req   = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = addr_q[MEM_ADDR_WIDTH+OFF-1:OFF];
                        mem_wdata = slave.w_data;
                        mem_wstrb = slave.w_strb;
                    end
                    // The burst ends on the beat count; w_last is only checked.
                    if (slave.w_last != last_beat) err_d = 1'b1;
                    if (last_beat) begin
                        state_d = WR_RESP;
                    end else begin
                        addr_d = addr_nxt;
                        cnt_d  = cnt_q + 8'd1;
                    end
                end
            end

            WR_RESP: begin
                slave.b_valid = 1'b1;
                slave.b_id    = id_q;
                slave.b_resp  = err_q ? RESP_SLVERR : RESP_OKAY;
                if (slave.b_ready) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            prio_wr_q  <= 1'b0;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            err_q      <= 1'b0;
            rd_first_q <= 1'b0;
            // NOTE: the read-data holding register is a plain flop, not an
            // SRAM, so it is reset like the rest of the datapath.
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            prio_wr_q  <= prio_wr_d;
            id_q       <= id_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            size_q     <= size_d;
            burst_q    <= burst_d;
            err_q      <= err_d;
            rd_first_q <= (state_q == RD_REQ);
            if (state_q == RD_DATA && rd_first_q) rdata_q <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;
    logic        clk;
    logic        rst;
    logic        mem_req;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic [63:0] mem_rdata;

    axi_channel #(.ID_WIDTH(8), .ADDR_WIDTH(48), .DATA_WIDTH(64)) axi ();

    axi_sram_slave #(
        .ID_WIDTH(8), .ADDR_WIDTH(48), .DATA_WIDTH(64), .MEM_ADDR_WIDTH(10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .slave     (axi),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // SRAM model plus a log of every request as {we, word address}.
    logic [63:0] sram [0:1023];
    logic [10:0] req_log [$];

    always @(posedge clk) begin
        if (mem_req) begin
            req_log.push_back({mem_we, mem_addr});
            if (mem_we) begin
                for (int b = 0; b < 8; b++)
                    if (mem_wstrb[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    logic [63:0] wbuf  [16];
    logic [7:0]  sbuf  [16];
    logic [63:0] expb  [16];
    logic [63:0] rbuf  [16];
    logic [1:0]  rrespb[16];
    logic        rlastb[16];
    logic [7:0]  rid_g;

    localparam int S_AW = 0, S_AR = 1, S_W = 2, S_R = 3, S_B = 4;

    function automatic logic sig(input int sel);
        case (sel)
            S_AW:    return axi.aw_ready;
            S_AR:    return axi.ar_ready;
            S_W:     return axi.w_ready;
            S_R:     return axi.r_valid;
            default: return axi.b_valid;
        endcase
    endfunction

    // Called at a falling edge; returns 1 ns after the falling edge where the
    // selected signal is seen high, or after the cycle budget runs out.
    task automatic wait_for(input int sel, input string tag);
        int n;
        n = 0;
        #1;
        while (!sig(sel)) begin
            @(negedge clk);
            #1;
            n++;
            if (n > 200) begin
                check({tag, "_timeout"}, 64'(sig(sel)), 64'd1);
                return;
            end
        end
    endtask

    task automatic send_aw(input logic [7:0] id, input logic [47:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        axi.aw_id = id; axi.aw_addr = addr; axi.aw_len = len;
        axi.aw_size = size; axi.aw_burst = burst; axi.aw_valid = 1'b1;
        wait_for(S_AW, "aw_ready");
        @(negedge clk);
        axi.aw_valid = 1'b0;
    endtask

    task automatic send_ar(input logic [7:0] id, input logic [47:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        axi.ar_id = id; axi.ar_addr = addr; axi.ar_len = len;
        axi.ar_size = size; axi.ar_burst = burst; axi.ar_valid = 1'b1;
        wait_for(S_AR, "ar_ready");
        @(negedge clk);
        axi.ar_valid = 1'b0;
    endtask

    task automatic send_w(input int len, input int last_beat);
        for (int i = 0; i <= len; i++) begin
            axi.w_data = wbuf[i]; axi.w_strb = sbuf[i];
            axi.w_last = (i == last_beat); axi.w_valid = 1'b1;
            wait_for(S_W, "w_ready");
            @(negedge clk);
        end
        axi.w_valid = 1'b0;
        axi.w_last  = 1'b0;
    endtask

    task automatic get_b(output logic [1:0] resp, output logic [7:0] bid);
        axi.b_ready = 1'b1;
        wait_for(S_B, "b_valid");
        resp = axi.b_resp;
        bid  = axi.b_id;
        @(negedge clk);
        axi.b_ready = 1'b0;
    endtask

    task automatic get_r(input int len, input int stall_beat, input int stall_cycles);
        for (int i = 0; i <= len; i++) begin
            wait_for(S_R, "r_valid");
            rbuf[i] = axi.r_data; rrespb[i] = axi.r_resp;
            rlastb[i] = axi.r_last; rid_g = axi.r_id;
            if (i == stall_beat) begin
                repeat (stall_cycles) begin
                    @(negedge clk);
                    #1;
                    check("stall_r_valid", 64'(axi.r_valid), 64'd1);
                    check("stall_r_data", axi.r_data, expb[i]);
                end
            end
            axi.r_ready = 1'b1;
            @(negedge clk);
            axi.r_ready = 1'b0;
        end
    endtask

    task automatic do_write(input logic [7:0] id, input logic [47:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int last_beat,
                            output logic [1:0] resp, output logic [7:0] bid);
        send_aw(id, addr, len, size, burst);
        send_w(int'(len), last_beat);
        get_b(resp, bid);
    endtask

    task automatic do_read(input logic [7:0] id, input logic [47:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int stall_beat, input int stall_cycles);
        send_ar(id, addr, len, size, burst);
        get_r(int'(len), stall_beat, stall_cycles);
    endtask

    task automatic check_log(input string tag, input int base, input int k,
                             input logic we, input logic [9:0] waddr);
        logic [10:0] entry;
        entry = (base + k < req_log.size()) ? req_log[base + k] : 11'h7FF;
        check(tag, 64'(entry), 64'({we, waddr}));
    endtask

    initial begin
        logic [1:0] resp;
        logic [7:0] bid;
        int         base;

        clk = 1'b0;
        rst = 1'b1;
        mem_rdata = '0;
        axi.aw_lock = 1'b0; axi.aw_cache = '0; axi.aw_prot = '0;
        axi.ar_lock = 1'b0; axi.ar_cache = '0; axi.ar_prot = '0;
        axi.w_data = '0; axi.w_strb = '0; axi.w_last = 1'b0; axi.w_valid = 1'b0;
        axi.b_ready = 1'b0; axi.r_ready = 1'b0;

        // Both address channels valid while still in reset.
        axi.ar_id = 8'h21; axi.ar_addr = 48'h0; axi.ar_len = 8'd0;
        axi.ar_size = 3'd3; axi.ar_burst = 2'b01; axi.ar_valid = 1'b1;
        axi.aw_id = 8'h31; axi.aw_addr = 48'h8; axi.aw_len = 8'd0;
        axi.aw_size = 3'd3; axi.aw_burst = 2'b01; axi.aw_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ar_ready", 64'(axi.ar_ready), 64'd0);
        check("rst_aw_ready", 64'(axi.aw_ready), 64'd0);
        check("rst_r_valid",  64'(axi.r_valid),  64'd0);
        check("rst_b_valid",  64'(axi.b_valid),  64'd0);
        check("rst_mem_req",  64'(mem_req),      64'd0);
        check("rst_r_data",   axi.r_data,        64'd0);

        // Arbitration: read first after reset, then write, then read again.
        rst = 1'b0;
        #1;
        check("arb1_ar_ready", 64'(axi.ar_ready), 64'd1);
        check("arb1_aw_ready", 64'(axi.aw_ready), 64'd0);
        @(negedge clk);
        axi.ar_valid = 1'b0;
        get_r(0, -1, 0);
        check("arb1_r_resp", 64'(rrespb[0]), 64'd0);
        check("arb1_r_last", 64'(rlastb[0]), 64'd1);
        check("arb1_r_id",   64'(rid_g),     64'h21);

        axi.ar_id = 8'h22; axi.ar_addr = 48'h8; axi.ar_valid = 1'b1;
        #1;
        check("arb2_aw_ready", 64'(axi.aw_ready), 64'd1);
        check("arb2_ar_ready", 64'(axi.ar_ready), 64'd0);
        @(negedge clk);
        axi.aw_valid = 1'b0;
        wbuf[0] = 64'hCAFE_F00D_0BAD_BEEF; sbuf[0] = 8'hFF;
        send_w(0, 0);
        get_b(resp, bid);
        check("arb2_b_resp", 64'(resp), 64'd0);
        check("arb2_b_id",   64'(bid),  64'h31);
        #1;
        check("arb3_ar_ready", 64'(axi.ar_ready), 64'd1);
        @(negedge clk);
        axi.ar_valid = 1'b0;
        get_r(0, -1, 0);
        check("arb3_r_data", rbuf[0], 64'hCAFE_F00D_0BAD_BEEF);
        check("arb3_r_id",   64'(rid_g), 64'h22);

        // Single write then read at 0x40.
        base = req_log.size();
        wbuf[0] = 64'h1122_3344_5566_7788; sbuf[0] = 8'hFF;
        do_write(8'h05, 48'h40, 8'd0, 3'd3, 2'b01, 0, resp, bid);
        check("single_b_resp", 64'(resp), 64'd0);
        check("single_b_id",   64'(bid),  64'h05);
        check_log("single_wr_addr", base, 0, 1'b1, 10'h008);
        do_read(8'h06, 48'h40, 8'd0, 3'd3, 2'b01, -1, 0);
        check("single_r_data", rbuf[0], 64'h1122_3344_5566_7788);
        check("single_r_last", 64'(rlastb[0]), 64'd1);
        check("single_r_resp", 64'(rrespb[0]), 64'd0);
        check("single_r_id",   64'(rid_g), 64'h06);

        // INCR 4-beat write and read at 0x100, beat 2 stalled for 5 cycles.
        base = req_log.size();
        for (int i = 0; i < 4; i++) begin
            wbuf[i] = 64'(i); sbuf[i] = 8'hFF; expb[i] = 64'(i);
        end
        do_write(8'h07, 48'h100, 8'd3, 3'd3, 2'b01, 3, resp, bid);
        check("incr_b_resp", 64'(resp), 64'd0);
        for (int i = 0; i < 4; i++) check_log("incr_wr_addr", base, i, 1'b1, 10'(10'h020 + i));
        base = req_log.size();
        do_read(8'h08, 48'h100, 8'd3, 3'd3, 2'b01, 1, 5);
        for (int i = 0; i < 4; i++) begin
            check("incr_r_data", rbuf[i], 64'(i));
            check("incr_r_last", 64'(rlastb[i]), 64'(i == 3));
            check_log("incr_rd_addr", base, i, 1'b0, 10'(10'h020 + i));
        end

        // WRAP 4-beat read at 0x110 after writing A..D to 0x100..0x118.
        wbuf[0] = 64'hAAAA; wbuf[1] = 64'hBBBB; wbuf[2] = 64'hCCCC; wbuf[3] = 64'hDDDD;
        do_write(8'h09, 48'h100, 8'd3, 3'd3, 2'b01, 3, resp, bid);
        base = req_log.size();
        do_read(8'h0A, 48'h110, 8'd3, 3'd3, 2'b10, -1, 0);
        check("wrap_r_data0", rbuf[0], 64'hCCCC);
        check("wrap_r_data1", rbuf[1], 64'hDDDD);
        check("wrap_r_data2", rbuf[2], 64'hAAAA);
        check("wrap_r_data3", rbuf[3], 64'hBBBB);
        check_log("wrap_addr0", base, 0, 1'b0, 10'h022);
        check_log("wrap_addr1", base, 1, 1'b0, 10'h023);
        check_log("wrap_addr2", base, 2, 1'b0, 10'h020);
        check_log("wrap_addr3", base, 3, 1'b0, 10'h021);

        // FIXED 2-beat read stays on one word.
        base = req_log.size();
        do_read(8'h0B, 48'h40, 8'd1, 3'd3, 2'b00, -1, 0);
        check_log("fixed_addr0", base, 0, 1'b0, 10'h008);
        check_log("fixed_addr1", base, 1, 1'b0, 10'h008);
        check("fixed_r_data1", rbuf[1], 64'h1122_3344_5566_7788);

        // Strobed write over an all-ones word.
        wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF; sbuf[0] = 8'hFF;
        do_write(8'h0C, 48'h0, 8'd0, 3'd3, 2'b01, 0, resp, bid);
        wbuf[0] = 64'h0; sbuf[0] = 8'h0F;
        do_write(8'h0C, 48'h0, 8'd0, 3'd3, 2'b01, 0, resp, bid);
        do_read(8'h0D, 48'h0, 8'd0, 3'd3, 2'b01, -1, 0);
        check("strb_r_data", rbuf[0], 64'hFFFF_FFFF_0000_0000);

        // Errors: oversize read, reserved burst write, early w_last.
        base = req_log.size();
        do_read(8'h0E, 48'h0, 8'd0, 3'd4, 2'b01, -1, 0);
        check("size_err_r_resp", 64'(rrespb[0]), 64'd2);
        check("size_err_r_data", rbuf[0], 64'd0);
        check("size_err_no_req", 64'(req_log.size() - base), 64'd0);
        base = req_log.size();
        wbuf[0] = 64'h1234; sbuf[0] = 8'hFF;
        do_write(8'h0F, 48'h0, 8'd0, 3'd3, 2'b11, 0, resp, bid);
        check("burst_err_b_resp", 64'(resp), 64'd2);
        check("burst_err_no_req", 64'(req_log.size() - base), 64'd0);
        base = req_log.size();
        for (int i = 0; i < 3; i++) begin wbuf[i] = 64'h77; sbuf[i] = 8'hFF; end
        do_write(8'h10, 48'h200, 8'd2, 3'd3, 2'b01, 1, resp, bid);
        check("wlast_err_b_resp", 64'(resp), 64'd2);
        check("wlast_err_b_id",   64'(bid),  64'h10);
        check("wlast_err_reqs",   64'(req_log.size() - base), 64'd2);

        // Reset while a read beat is presented.
        send_ar(8'h11, 48'h40, 8'd0, 3'd3, 2'b01);
        wait_for(S_R, "pre_rst_r_valid");
        rst = 1'b1;
        #1;
        check("midrst_r_valid", 64'(axi.r_valid), 64'd0);
        check("midrst_mem_req", 64'(mem_req), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("postrst_r_valid", 64'(axi.r_valid), 64'd0);
        @(negedge clk);
        do_read(8'h12, 48'h40, 8'd0, 3'd3, 2'b01, -1, 0);
        check("postrst_r_data", rbuf[0], 64'h1122_3344_5566_7788);
        check("postrst_r_id",   64'(rid_g), 64'h12);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
